kart_physics: RTL

// Per-frame kart motion stage feeding forward_view. On each new_frame_in pulse it reads

---
 rtl/kart_physics.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/kart_physics.sv
// Per-frame kart motion: steer, speed with terrain cap, 11.4 position update, commit.
// Latency: new_frame_in at cycle 0 -> done_out and new outputs at cycle 6; frames arriving while busy are dropped.
module kart_physics #(
  parameter int START_X      = 1024,
  parameter int START_Y      = 1536,
  parameter int START_DIR    = 0,
  parameter int STEER_STEP   = 3,
  parameter int ACCEL        = 2,
  parameter int BRAKE        = 4,
  parameter int FRICTION     = 1,
  parameter int MAX_SPEED    = 64,
  parameter int OFFROAD_TYPE = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               new_frame_in,
  input  logic               btn_accel_in,
  input  logic               btn_brake_in,
  input  logic               btn_left_in,
  input  logic               btn_right_in,
  output logic [8:0]         trig_addr_out,
  input  logic signed [10:0] sin_in,
  input  logic signed [10:0] cos_in,
  output logic [7:0]         track_addr_out,
  input  logic [3:0]         terrain_in,
  output logic [8:0]         direction_out,
  output logic [10:0]        player_x_out,
  output logic [10:0]        player_y_out,
  output logic [7:0]         speed_out,
  output logic               busy_out,
  output logic               done_out
);

  typedef enum logic [2:0] {IDLE, STEER, LOOKUP, WAIT, SPEED, MOVE, COMMIT} state_t;

  localparam logic [8:0]        RST_DIR = 9'(START_DIR);
  localparam logic [14:0]       RST_X   = 15'(START_X * 16);
  localparam logic [14:0]       RST_Y   = 15'(START_Y * 16);
  localparam logic [8:0]        STEP9   = 9'(STEER_STEP);
  localparam logic signed [9:0] ACC_S   = 10'(ACCEL);
  localparam logic signed [9:0] BRK_S   = 10'(BRAKE);
  localparam logic signed [9:0] FRC_S   = 10'(FRICTION);

  state_t state, state_nxt;
  logic [8:0]         dir, dir_nxt;
  logic [14:0]        pos_x, pos_y, pos_x_nxt, pos_y_nxt;
  logic [7:0]         speed, spd_nxt, cap;
  logic signed [9:0]  spd_raw;
  logic signed [10:0] sin_q, cos_q;
  logic signed [19:0] spd_e, sin_e, cos_e, prod_x, prod_y, dx, dy, nx, ny;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (new_frame_in) state_nxt = STEER;
      STEER:   state_nxt = LOOKUP;
      LOOKUP:  state_nxt = WAIT;
      WAIT:    state_nxt = SPEED;
      SPEED:   state_nxt = MOVE;
      MOVE:    state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Heading only changes while moving; wrap stays inside 0..359.
  always_comb begin
    dir_nxt = dir;
    if (speed != 8'd0) begin
      if (btn_left_in && !btn_right_in)
        dir_nxt = (dir >= STEP9) ? dir - STEP9 : dir + 9'd360 - STEP9;
      else if (btn_right_in && !btn_left_in)
        dir_nxt = (dir + STEP9 >= 9'd360) ? dir + STEP9 - 9'd360 : dir + STEP9;
    end
  end

  always_comb begin
    cap     = (terrain_in >= 4'(OFFROAD_TYPE)) ? 8'(MAX_SPEED >> 1) : 8'(MAX_SPEED);
    spd_raw = $signed({2'b00, speed});
    if (btn_brake_in)      spd_raw = spd_raw - BRK_S;
    else if (btn_accel_in) spd_raw = spd_raw + ACC_S;
    else                   spd_raw = spd_raw - FRC_S;
    if (spd_raw < 10'sd0)                           spd_nxt = 8'd0;
    else if (spd_raw > $signed({2'b00, cap}))       spd_nxt = cap;
    else                                            spd_nxt = spd_raw[7:0];
  end

  // Arithmetic shift floors negative displacements; heading 0 moves toward y=0.
  always_comb begin
    spd_e  = {12'd0, speed};
    sin_e  = {{9{sin_q[10]}}, sin_q};
    cos_e  = {{9{cos_q[10]}}, cos_q};
    prod_x = spd_e * sin_e;
    prod_y = spd_e * cos_e;
    dx     = prod_x >>> 9;
    dy     = -(prod_y >>> 9);
    nx     = $signed({5'd0, pos_x}) + dx;
    ny     = $signed({5'd0, pos_y}) + dy;
    if (nx < 20'sd0)            pos_x_nxt = 15'd0;
    else if (nx > 20'sd32767)   pos_x_nxt = 15'd32767;
    else                        pos_x_nxt = nx[14:0];
    if (ny < 20'sd0)            pos_y_nxt = 15'd0;
    else if (ny > 20'sd32767)   pos_y_nxt = 15'd32767;
    else                        pos_y_nxt = ny[14:0];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      dir           <= RST_DIR;
      pos_x         <= RST_X;
      pos_y         <= RST_Y;
      speed         <= 8'd0;
      sin_q         <= '0;
      cos_q         <= '0;
      direction_out <= RST_DIR;
      player_x_out  <= RST_X[14:4];
      player_y_out  <= RST_Y[14:4];
      speed_out     <= 8'd0;
    end else begin
      case (state)
        STEER: dir <= dir_nxt;
        SPEED: begin
          speed <= spd_nxt;
          sin_q <= sin_in;
          cos_q <= cos_in;
        end
        // Outputs load on the edge into COMMIT so they are new alongside done_out.
        MOVE: begin
          pos_x         <= pos_x_nxt;
          pos_y         <= pos_y_nxt;
          direction_out <= dir;
          player_x_out  <= pos_x_nxt[14:4];
          player_y_out  <= pos_y_nxt[14:4];
          speed_out     <= speed;
        end
        default: ;
      endcase
    end
  end

  assign trig_addr_out  = dir;
  assign track_addr_out = {pos_y[10:7], pos_x[10:7]};
  assign busy_out       = (state != IDLE);
  assign done_out       = (state == COMMIT);

endmodule
